// File: rtl/video_scanout.sv
// VGA-style raster scanout of a 16x16 one-bit video RAM, each cell drawn as a CELL_W x CELL_H block.
// Optional build macro GRID_LINES_EN overlays a one-pixel border on every cell.
module video_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL_W   = 30,
    parameter int CELL_H   = 30,
    parameter int X_OFFSET = 80,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [3:0] ram_x,
    output logic [3:0] ram_y,
    input  logic       ram_rd_data,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       pix,
    output logic       in_grid,
    output logic       vblank,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int SX_W    = $clog2(CELL_W + 1);
    localparam int SY_W    = $clog2(CELL_H + 1);

    localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT   = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] V_ACT   = VC_W'(V_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HC_W-1:0] GX_BEG  = HC_W'(X_OFFSET);
    localparam logic [HC_W-1:0] GX_END  = HC_W'(X_OFFSET + 16 * CELL_W);
    localparam logic [HC_W-1:0] GX_PRE  = (X_OFFSET == 0) ? H_LAST : HC_W'(X_OFFSET - 1);
    localparam logic [VC_W-1:0] GY_END  = VC_W'(16 * CELL_H);
    localparam logic [SX_W-1:0] SX_LAST = SX_W'(CELL_W - 1);
    localparam logic [SY_W-1:0] SY_LAST = SY_W'(CELL_H - 1);
    localparam logic            SYNC_ACT = (SYNC_POL != 0);

    if ((16 * CELL_W + X_OFFSET > H_ACTIVE) || (16 * CELL_H > V_ACTIVE)) begin : g_bad_grid
        $error("video_scanout: 16x16 grid does not fit inside the active area");
    end

    logic [HC_W-1:0] hcnt, hcnt_nxt;
    logic [VC_W-1:0] vcnt, vcnt_nxt;
    logic [SX_W-1:0] sx, sx_nxt;
    logic [SY_W-1:0] sy, sy_nxt;
    logic [3:0]      cx, cx_nxt, cy, cy_nxt;
    logic            vld_p0;
    logic            h_wrap, v_wrap, h_in, v_in, h_in_nxt, v_in_nxt;
    logic            hs_p0, vs_p0, de_p0, grid_p0, pix_p0;
    logic            hsync_p1, vsync_p1, de_p1, grid_p1, pix_p1, fs_p1;
    logic [3:0]      ram_x_p1, ram_y_p1;

    assign vld_p0 = en;

    // Stage p0: raster position decode and next-state of all counters
    always_comb begin
        h_wrap   = (hcnt == H_LAST);
        v_wrap   = (vcnt == V_LAST);
        hcnt_nxt = h_wrap ? '0 : hcnt + 1'b1;
        vcnt_nxt = vcnt;
        if (h_wrap) vcnt_nxt = v_wrap ? '0 : vcnt + 1'b1;

        h_in     = (hcnt >= GX_BEG) && (hcnt < GX_END);
        v_in     = (vcnt < GY_END);
        h_in_nxt = (hcnt_nxt >= GX_BEG) && (hcnt_nxt < GX_END);
        v_in_nxt = (vcnt_nxt < GY_END);

        sx_nxt = sx;
        cx_nxt = cx;
        if (hcnt == GX_PRE) begin
            sx_nxt = '0;
            cx_nxt = '0;
        end else if (h_in) begin
            if (sx == SX_LAST) begin
                sx_nxt = '0;
                cx_nxt = cx + 1'b1;
            end else begin
                sx_nxt = sx + 1'b1;
            end
        end

        sy_nxt = sy;
        cy_nxt = cy;
        if (h_wrap) begin
            if (v_wrap) begin
                sy_nxt = '0;
                cy_nxt = '0;
            end else if (v_in) begin
                if (sy == SY_LAST) begin
                    sy_nxt = '0;
                    cy_nxt = cy + 1'b1;
                end else begin
                    sy_nxt = sy + 1'b1;
                end
            end
        end

        hs_p0   = (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_p0   = (vcnt >= VS_BEG) && (vcnt < VS_END);
        de_p0   = (hcnt < H_ACT) && (vcnt < V_ACT);
        grid_p0 = h_in && v_in;
`ifdef GRID_LINES_EN
        pix_p0  = (ram_rd_data | (sx == '0) | (sy == '0)) & grid_p0 & de_p0;
`else
        pix_p0  = ram_rd_data & grid_p0 & de_p0;
`endif
    end

    // Stage p1: registered outputs, one pixel behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt     <= '0;
            vcnt     <= '0;
            sx       <= '0;
            sy       <= '0;
            cx       <= '0;
            cy       <= '0;
            ram_x_p1 <= '0;
            ram_y_p1 <= '0;
            hsync_p1 <= ~SYNC_ACT;
            vsync_p1 <= ~SYNC_ACT;
            de_p1    <= 1'b0;
            grid_p1  <= 1'b0;
            pix_p1   <= 1'b0;
            fs_p1    <= 1'b0;
        end else if (vld_p0) begin
            hcnt     <= hcnt_nxt;
            vcnt     <= vcnt_nxt;
            sx       <= sx_nxt;
            sy       <= sy_nxt;
            cx       <= cx_nxt;
            cy       <= cy_nxt;
            // Address tracks the cell of the new position so RAM data is ready by the next tick
            if (h_in_nxt && v_in_nxt) begin
                ram_x_p1 <= cx_nxt;
                ram_y_p1 <= cy_nxt;
            end
            hsync_p1 <= hs_p0 ? SYNC_ACT : ~SYNC_ACT;
            vsync_p1 <= vs_p0 ? SYNC_ACT : ~SYNC_ACT;
            de_p1    <= de_p0;
            grid_p1  <= grid_p0;
            pix_p1   <= pix_p0;
            fs_p1    <= h_wrap && v_wrap;
        end else begin
            fs_p1    <= 1'b0;
        end
    end

    assign ram_x       = ram_x_p1;
    assign ram_y       = ram_y_p1;
    assign hsync       = hsync_p1;
    assign vsync       = vsync_p1;
    assign de          = de_p1;
    assign in_grid     = grid_p1;
    assign pix         = pix_p1;
    assign frame_start = fs_p1;
    assign vblank      = (vcnt >= V_ACT);

endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
- Downstream consumer of the 16x16 one-bit video RAM.
- Generates 640x480 VGA-style raster timing and reads one RAM cell per scaled pixel block, with each cell shown as a CELL_W x CELL_H square.
- Emits sync, data-enable and a pixel bit to the display output stage.
- Exports vblank so game logic can confine its RAM writes to the blanking interval.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CELL_W, 30, display pixels per cell horizontally
- CELL_H, 30, display lines per cell vertically
- X_OFFSET, 80, first active column of the grid
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  pixel tick; all state advances only when en=1
- ram_x  out  4  cell column address to RAM
- ram_y  out  4  cell row address to RAM
- ram_rd_data  in  1  RAM read bit; valid one clk after the address changes
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video enable
- pix  out  1  pixel value
- in_grid  out  1  current output pixel lies inside the 16x16 grid
- vblank  out  1  high while the vertical counter is ≥ V_ACTIVE
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Counters: hcnt 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800). vcnt 0..V_TOTAL-1 (525).
  - hcnt increments on en; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps at V_TOTAL-1.
- Cell sub-counters:
  - sx counts 0..CELL_W-1 while hcnt is in [X_OFFSET, X_OFFSET+16*CELL_W). On sx wrap, cx (4 bits) increments.
  - cx and sx clear when hcnt=X_OFFSET-1.
  - sy/cy behave the same on line wrap while vcnt < 16*CELL_H. They clear at the end of the frame.
  - No divider or multiplier is used.
- Address: ram_x=cx and ram_y=cy, registered and updated on the same en tick as the counters. Outside the grid they hold their last value.
- Pipeline, one pixel of latency:
  - On each en tick the output registers capture hsync, vsync, de and in_grid for the previous counter position.
  - On the same tick, pix captures ram_rd_data & in_grid & de.
  - Requirement: the RAM read latency is ≤1 clk, and en ticks are never in consecutive-cycle conflict with a RAM-latency longer than the en spacing.
- Sync timing:
  - hsync is active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is handled the same way on vcnt.
  - The active level is SYNC_POL.
- de = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE), delayed one stage.
- vblank is combinational from vcnt (not delayed).
- frame_start: a single-clk pulse in the clk cycle when en=1 and the counters wrap from (H_TOTAL-1, V_TOTAL-1). It never lasts more than one clk, even if en stays high.
- en=0: all registers hold and frame_start stays 0.
- Reset values:
  - All counters 0.
  - ram_x=0, ram_y=0, pix=0, de=0, in_grid=0, frame_start=0.
  - hsync and vsync at the inactive level (!SYNC_POL).
  - vblank=0.
- Reset mid-frame: takes effect on the next clk regardless of en, and the raster restarts at (0,0).
- Parameter check: 16*CELL_W+X_OFFSET must be ≤ H_ACTIVE and 16*CELL_H must be ≤ V_ACTIVE. The grid must never address outside 0..15.

Optional Feature:
- GRID_LINES_EN
  - Defined: pix is forced to 1 inside the grid wherever sx==0 or sy==0, giving a one-pixel cell-border overlay. The forced pixel is pipelined identically to the RAM data.
  - Undefined: pix is pure RAM data, and the sx/sy compare logic is absent.

Test Plan:
- Reset, then en=1 every clk for 800*525 clks:
  - exactly one frame_start pulse at clk 420000;
  - hsync is low for 96 clks starting 657 clks after each line start (656 + 1 pipeline);
  - vsync is low for lines 490-491.
- Preload RAM cell (1,2)=1 and all others 0:
  - pix=1 only for hcnt 110..139 (+1 latency) on lines 60..89;
  - ram_x=1, ram_y=2 throughout that block.
- Preload cell (15,15)=1 and cell (0,0)=1:
  - pixels at columns 80 and 559 are set, on lines 0 and 479;
  - pix=0 at column 560 and at column 79.
- en toggling every other clk: the raster period doubles to 840000 clks; output values match the en=1 run tick-for-tick.
- Assert rst at line 200, hcnt 300:
  - next clk: all outputs at reset values and hsync/vsync inactive;
  - after release, frame_start fires after 420000 en ticks.
- With GRID_LINES_EN and the RAM cleared: pix=1 at columns 80, 110, ..., 530 and on lines 0, 30, ..., 450; pix=0 elsewhere.
